// File: rtl/switch_debouncer.sv
// ---------------------------------------------------------------------------
// switch_debouncer
//
// Conditions raw slide-switch levels before they reach the display logic.
// Each switch bit passes through a two-flop synchronizer and then a per-bit
// stability counter. A bit of SW_DB only adopts a new value once the
// synchronized switch has disagreed with it for STABLE_CYCLES consecutive
// clocks. Any cycle of agreement throws the partial count away, so bounce
// and short glitches never reach SW_DB.
//
// Ports:
//   CLOCK_50    in   1        system clock, all logic on the rising edge
//   reset       in   1        synchronous, active-high reset
//   SW          in   NUM_SW   raw asynchronous switch levels
//   SW_DB       out  NUM_SW   debounced switch levels (registered)
//   SW_RISE     out  NUM_SW   one-cycle pulse when an SW_DB bit goes 0->1
//   SW_FALL     out  NUM_SW   one-cycle pulse when an SW_DB bit goes 1->0
//   SW_CHANGED  out  1        OR of all rise/fall pulses, same cycle
//
// Parameters:
//   NUM_SW         number of switch bits handled
//   STABLE_CYCLES  consecutive disagreeing cycles needed to flip SW_DB (>= 2)
//   CNT_W          per-bit counter width, must hold STABLE_CYCLES-1
// ---------------------------------------------------------------------------
module switch_debouncer #(
   parameter int unsigned NUM_SW        = 6,
   parameter int unsigned STABLE_CYCLES = 500000,
   parameter int unsigned CNT_W         = 19
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic [0:NUM_SW-1] SW,
   output logic [0:NUM_SW-1] SW_DB,
   output logic [0:NUM_SW-1] SW_RISE,
   output logic [0:NUM_SW-1] SW_FALL,
   output logic              SW_CHANGED
);

   // Terminal count: once a bit has disagreed for this many edges already,
   // one more disagreeing edge commits the new level.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [0:NUM_SW-1] sync1;
   logic [0:NUM_SW-1] sync2;
   logic [CNT_W-1:0]  cnt      [NUM_SW];
   logic [CNT_W-1:0]  cnt_next [NUM_SW];
   logic [0:NUM_SW-1] db_next;
   logic [0:NUM_SW-1] rise_next;
   logic [0:NUM_SW-1] fall_next;

   // Two-flop synchronizer for the asynchronous switch inputs. Only sync2
   // is ever looked at downstream, sync1 is allowed to go metastable.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= SW;
         sync2 <= sync1;
      end
   end

   // Per-bit stability decision. Every bit is evaluated on its own: agreement
   // with SW_DB clears the counter, disagreement either advances it or, at
   // the terminal count, commits the new level and raises the matching pulse.
   // The counter is cleared on commit so it never runs past CNT_LAST.
   always_comb begin
      db_next   = SW_DB;
      rise_next = '0;
      fall_next = '0;
      for (int i = 0; i < int'(NUM_SW); i++) begin
         cnt_next[i] = '0;
         if (sync2[i] != SW_DB[i]) begin
            if (cnt[i] == CNT_LAST) begin
               db_next[i]   = sync2[i];
               rise_next[i] = sync2[i];
               fall_next[i] = ~sync2[i];
            end else begin
               cnt_next[i] = cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Output and counter registers. Pulses are registered together with the
   // new SW_DB value so they line up with the first cycle SW_DB shows it.
   // Reset wins over everything, including any count in progress.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         SW_DB      <= '0;
         SW_RISE    <= '0;
         SW_FALL    <= '0;
         SW_CHANGED <= 1'b0;
         for (int i = 0; i < int'(NUM_SW); i++) begin
            cnt[i] <= '0;
         end
      end else begin
         SW_DB      <= db_next;
         SW_RISE    <= rise_next;
         SW_FALL    <= fall_next;
         SW_CHANGED <= |{rise_next, fall_next};
         for (int i = 0; i < int'(NUM_SW); i++) begin
            cnt[i] <= cnt_next[i];
         end
      end
   end

endmodule

// File: tb/tb_switch_debouncer.sv
// ---------------------------------------------------------------------------
// tb_switch_debouncer
//
// Self-checking bench for switch_debouncer with STABLE_CYCLES=4, CNT_W=3.
// Inputs change on the falling edge, outputs are compared on the falling
// edge after each rising edge. A reference model follows every edge and is
// compared every cycle. A table of hand-derived vectors and a few directed
// sequences pin down exact latencies, and a random phase finishes the run.
// Note SW[0] is the leftmost bit of a 6'b literal because ports are [0:5].
// ---------------------------------------------------------------------------
module tb_switch_debouncer;

   localparam int NUM_SW = 6;
   localparam int STABLE = 4;
   localparam int CNT_W  = 3;
   localparam int MAXE   = 16384;

   logic              CLOCK_50 = 1'b0;
   logic              reset;
   logic [0:NUM_SW-1] SW;
   logic [0:NUM_SW-1] SW_DB;
   logic [0:NUM_SW-1] SW_RISE;
   logic [0:NUM_SW-1] SW_FALL;
   logic              SW_CHANGED;

   int total = 0;
   int bad   = 0;

   // Reference model state: per-edge history of raw samples, reset samples
   // and the synchronized value each edge sees, plus the edge of the last
   // event (reset or flip) for every bit.
   logic [0:NUM_SW-1] raw_hist [MAXE];
   logic              rst_hist [MAXE];
   logic [0:NUM_SW-1] syn_hist [MAXE];
   int                n = 0;
   int                last_evt [NUM_SW];
   logic [0:NUM_SW-1] m_db;
   logic [0:NUM_SW-1] m_rise;
   logic [0:NUM_SW-1] m_fall;
   logic              m_chg;

   typedef struct {
      logic [0:NUM_SW-1] sw;
      logic              rst;
      logic [0:NUM_SW-1] db;
      logic [0:NUM_SW-1] rise;
      logic [0:NUM_SW-1] fall;
      logic              chg;
   } vec_t;

   vec_t tbl [$];

   switch_debouncer #(
      .NUM_SW        (NUM_SW),
      .STABLE_CYCLES (STABLE),
      .CNT_W         (CNT_W)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .SW         (SW),
      .SW_DB      (SW_DB),
      .SW_RISE    (SW_RISE),
      .SW_FALL    (SW_FALL),
      .SW_CHANGED (SW_CHANGED)
   );

   // 50 MHz-style free running clock.
   always #5 CLOCK_50 = ~CLOCK_50;

   // Model of one rising edge. The synchronized value seen at edge n is the
   // raw sample from two edges earlier, or 0 if a reset edge lies in between.
   // A bit flips when the last STABLE synchronized values since its last
   // event all disagree with the debounced level.
   task automatic modelEdge(input logic [0:NUM_SW-1] sw, input logic rst);
      logic [0:NUM_SW-1] syn;
      logic              flip;
      n++;
      raw_hist[n] = sw;
      rst_hist[n] = rst;
      m_rise = '0;
      m_fall = '0;
      if (rst) begin
         m_db = '0;
         syn_hist[n] = '0;
         for (int i = 0; i < NUM_SW; i++) last_evt[i] = n;
      end else begin
         if (n < 3 || rst_hist[n-1] || rst_hist[n-2]) syn = '0;
         else syn = raw_hist[n-2];
         syn_hist[n] = syn;
         for (int i = 0; i < NUM_SW; i++) begin
            flip = (n - last_evt[i] >= STABLE);
            for (int k = 0; k < STABLE; k++) begin
               if (flip && syn_hist[n-k][i] == m_db[i]) flip = 1'b0;
            end
            if (flip) begin
               m_db[i]     = syn[i];
               m_rise[i]   = syn[i];
               m_fall[i]   = ~syn[i];
               last_evt[i] = n;
            end
         end
      end
      m_chg = |{m_rise, m_fall};
   endtask

   task automatic checkOutput(input string name);
      total++;
      if ({SW_DB, SW_RISE, SW_FALL, SW_CHANGED} !== {m_db, m_rise, m_fall, m_chg}) begin
         bad++;
         $display("[TB] FAIL %s edge=%0d: got db=%b rise=%b fall=%b chg=%b, want db=%b rise=%b fall=%b chg=%b",
                  name, n, SW_DB, SW_RISE, SW_FALL, SW_CHANGED, m_db, m_rise, m_fall, m_chg);
      end
   endtask

   task automatic checkConst(input string name, input logic [0:NUM_SW-1] db,
                             input logic [0:NUM_SW-1] rise, input logic [0:NUM_SW-1] fall,
                             input logic chg);
      total++;
      if ({SW_DB, SW_RISE, SW_FALL, SW_CHANGED} !== {db, rise, fall, chg}) begin
         bad++;
         $display("[TB] FAIL %s edge=%0d: got db=%b rise=%b fall=%b chg=%b, want db=%b rise=%b fall=%b chg=%b",
                  name, n, SW_DB, SW_RISE, SW_FALL, SW_CHANGED, db, rise, fall, chg);
      end
   endtask

   // Drive one cycle: inputs set away from the edge, model stepped on the
   // edge, DUT compared to the model on the following falling edge.
   task automatic applyStimulus(input logic [0:NUM_SW-1] sw, input logic rst);
      SW    = sw;
      reset = rst;
      @(posedge CLOCK_50);
      modelEdge(sw, rst);
      @(negedge CLOCK_50);
      checkOutput("model");
   endtask

   function automatic vec_t mk(input logic [0:NUM_SW-1] sw, input logic rst,
                               input logic [0:NUM_SW-1] db, input logic [0:NUM_SW-1] rise,
                               input logic [0:NUM_SW-1] fall, input logic chg);
      vec_t v;
      v.sw = sw; v.rst = rst; v.db = db; v.rise = rise; v.fall = fall; v.chg = chg;
      return v;
   endfunction

   initial begin
      logic [0:NUM_SW-1] cur;
      logic              rnd_rst;

      SW    = '0;
      reset = 1'b1;
      for (int i = 0; i < NUM_SW; i++) last_evt[i] = 0;

      // Reset held three cycles, then released with switches low.
      repeat (3) tbl.push_back(mk(6'b000000, 1'b1, 6'b000000, 6'b000000, 6'b000000, 1'b0));
      repeat (2) tbl.push_back(mk(6'b000000, 1'b0, 6'b000000, 6'b000000, 6'b000000, 1'b0));
      // SW[0] rises cleanly: five edges of latency, then a single pulse.
      repeat (5) tbl.push_back(mk(6'b100000, 1'b0, 6'b000000, 6'b000000, 6'b000000, 1'b0));
      tbl.push_back(mk(6'b100000, 1'b0, 6'b100000, 6'b100000, 6'b000000, 1'b1));
      tbl.push_back(mk(6'b100000, 1'b0, 6'b100000, 6'b000000, 6'b000000, 1'b0));
      // One-cycle glitch on SW[3] is filtered out.
      tbl.push_back(mk(6'b100100, 1'b0, 6'b100000, 6'b000000, 6'b000000, 1'b0));
      repeat (6) tbl.push_back(mk(6'b100000, 1'b0, 6'b100000, 6'b000000, 6'b000000, 1'b0));

      foreach (tbl[r]) begin
         applyStimulus(tbl[r].sw, tbl[r].rst);
         checkConst($sformatf("tbl%0d", r), tbl[r].db, tbl[r].rise, tbl[r].fall, tbl[r].chg);
      end

      // SW[2] bounces (three high, one low) four times, then holds high.
      for (int rep = 0; rep < 4; rep++) begin
         for (int j = 0; j < 4; j++) begin
            applyStimulus((j < 3) ? 6'b101000 : 6'b100000, 1'b0);
            checkConst("bounce", 6'b100000, 6'b000000, 6'b000000, 1'b0);
         end
      end
      for (int j = 0; j < 5; j++) begin
         applyStimulus(6'b101000, 1'b0);
         checkConst("hold_wait", 6'b100000, 6'b000000, 6'b000000, 1'b0);
      end
      applyStimulus(6'b101000, 1'b0);
      checkConst("hold_rise", 6'b101000, 6'b001000, 6'b000000, 1'b1);
      applyStimulus(6'b101000, 1'b0);
      checkConst("hold_after", 6'b101000, 6'b000000, 6'b000000, 1'b0);

      // Bring SW_DB[5] high, then flip SW[1] up and SW[5] down together.
      repeat (8) applyStimulus(6'b101001, 1'b0);
      checkConst("sim_setup", 6'b101001, 6'b000000, 6'b000000, 1'b0);
      for (int j = 0; j < 5; j++) begin
         applyStimulus(6'b111000, 1'b0);
         checkConst("sim_wait", 6'b101001, 6'b000000, 6'b000000, 1'b0);
      end
      applyStimulus(6'b111000, 1'b0);
      checkConst("sim_flip", 6'b111000, 6'b010000, 6'b000001, 1'b1);
      applyStimulus(6'b111000, 1'b0);
      checkConst("sim_after", 6'b111000, 6'b000000, 6'b000000, 1'b0);

      // SW[4] held high, reset pulsed after two counts; count must restart.
      repeat (8) applyStimulus(6'b000000, 1'b0);
      checkConst("rst_setup", 6'b000000, 6'b000000, 6'b000000, 1'b0);
      for (int j = 0; j < 4; j++) begin
         applyStimulus(6'b000010, 1'b0);
         checkConst("rst_pre", 6'b000000, 6'b000000, 6'b000000, 1'b0);
      end
      applyStimulus(6'b000010, 1'b1);
      checkConst("rst_pulse", 6'b000000, 6'b000000, 6'b000000, 1'b0);
      for (int j = 0; j < 5; j++) begin
         applyStimulus(6'b000010, 1'b0);
         checkConst("rst_wait", 6'b000000, 6'b000000, 6'b000000, 1'b0);
      end
      applyStimulus(6'b000010, 1'b0);
      checkConst("rst_rise", 6'b000010, 6'b000010, 6'b000000, 1'b1);

      // Random switch activity with occasional resets, checked by the model.
      cur = 6'b000010;
      for (int c = 0; c < 2000; c++) begin
         for (int b = 0; b < NUM_SW; b++) begin
            if ($urandom_range(0, 4) == 0) cur[b] = ~cur[b];
         end
         rnd_rst = ($urandom_range(0, 99) == 0);
         applyStimulus(cur, rnd_rst);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
